// File: rtl/mem_arbiter_if.sv
// Bundle of request, completion and RAM signals around mem_arbiter.
// The io_buffer_full input exists only when MEMCTRL_IO_STALL_EN is defined.
interface mem_arbiter_if #(
    parameter int LINE_BYTES = 16,
    parameter int RD_CH      = 2
);
    localparam int LEN_W = $clog2(LINE_BYTES);

    logic                      rdy;
    logic                      flush;
    logic                      wr_valid;
    logic [31:0]               wr_addr;
    logic [31:0]               wr_data;
    logic [1:0]                wr_len;
    logic                      wr_done;
    logic [RD_CH-1:0]          rd_valid;
    logic [RD_CH*32-1:0]       rd_addr;
    logic [RD_CH*LEN_W-1:0]    rd_len;
    logic [RD_CH-1:0]          rd_done;
    logic [LINE_BYTES*8-1:0]   rd_data;
    logic                      busy;
    logic                      ram_rw_sel;
    logic [31:0]               ram_addr;
    logic [7:0]                ram_wr_byte;
    logic [7:0]                ram_rd_byte;
`ifdef MEMCTRL_IO_STALL_EN
    logic                      io_buffer_full;
`endif

    modport slave (
`ifdef MEMCTRL_IO_STALL_EN
        input  io_buffer_full,
`endif
        input  rdy, flush,
        input  wr_valid, wr_addr, wr_data, wr_len,
        input  rd_valid, rd_addr, rd_len,
        input  ram_rd_byte,
        output wr_done, rd_done, rd_data, busy,
        output ram_rw_sel, ram_addr, ram_wr_byte
    );

    modport master (
`ifdef MEMCTRL_IO_STALL_EN
        output io_buffer_full,
`endif
        output rdy, flush,
        output wr_valid, wr_addr, wr_data, wr_len,
        output rd_valid, rd_addr, rd_len,
        output ram_rd_byte,
        input  wr_done, rd_done, rd_data, busy,
        input  ram_rw_sel, ram_addr, ram_wr_byte
    );
endinterface

// File: rtl/mem_arbiter.sv
// Byte-serial controller: one write channel (fixed priority) and RD_CH round-robin read channels
// sharing a byte-wide single-port RAM. Optional macro MEMCTRL_IO_STALL_EN holds IO writes off.
//
// state | meaning
// IDLE  | arbitrate; at least one cycle between transactions
// WRITE | stream wr_data bytes to RAM, one per cycle
// READ  | issue addresses, capture returning bytes into the line buffer
module mem_arbiter #(
    parameter int               LINE_BYTES = 16,
    parameter int               RD_CH      = 2,
    parameter logic [RD_CH-1:0] KILL_MASK  = RD_CH'(1)
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    localparam int LEN_W = $clog2(LINE_BYTES);
    localparam int CNT_W = LEN_W + 1;
    localparam int CH_W  = (RD_CH > 1) ? $clog2(RD_CH) : 1;

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [CH_W-1:0]         ch_q, ch_d;
    logic [CH_W-1:0]         ptr_q, ptr_d;
    logic [31:0]             wr_data_q, wr_data_d;
    logic [31:0]             ram_addr_q, ram_addr_d;
    logic                    ram_rw_sel_q, ram_rw_sel_d;
    logic [7:0]              ram_wr_byte_q, ram_wr_byte_d;
    logic                    wr_done_q, wr_done_d;
    logic [RD_CH-1:0]        rd_done_q, rd_done_d;
    logic [LINE_BYTES*8-1:0] rd_data_q, rd_data_d;
    logic [LINE_BYTES*8-1:0] buf_q, buf_d;

    logic [RD_CH-1:0]        elig;
    logic                    gnt_found;
    logic [CH_W-1:0]         gnt_ch;
    logic [CH_W-1:0]         cand;
    logic                    wr_block;
    logic [CNT_W-1:0]        cnt_nxt;
    logic [CNT_W-1:0]        len_p1;
    logic [LEN_W-1:0]        cap_idx;

`ifdef MEMCTRL_IO_STALL_EN
    assign wr_block = bus.io_buffer_full && (bus.wr_addr[17:16] == 2'b11);
`else
    assign wr_block = 1'b0;
`endif

    always_comb begin
        for (int c = 0; c < RD_CH; c++) begin
            elig[c] = bus.rd_valid[c] && !rd_done_q[c] && !(bus.flush && KILL_MASK[c]);
        end
    end

    // First eligible channel at or after the pointer, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_ch    = '0;
        cand      = '0;
        for (int i = 0; i < RD_CH; i++) begin
            cand = CH_W'((int'(ptr_q) + i) % RD_CH);
            if (!gnt_found && elig[cand]) begin
                gnt_found = 1'b1;
                gnt_ch    = cand;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        len_d         = len_q;
        ch_d          = ch_q;
        ptr_d         = ptr_q;
        wr_data_d     = wr_data_q;
        ram_addr_d    = ram_addr_q;
        ram_rw_sel_d  = ram_rw_sel_q;
        ram_wr_byte_d = ram_wr_byte_q;
        wr_done_d     = wr_done_q;
        rd_done_d     = rd_done_q;
        rd_data_d     = rd_data_q;
        buf_d         = buf_q;
        cnt_nxt       = cnt_q + CNT_W'(1);
        len_p1        = CNT_W'(len_q) + CNT_W'(1);
        cap_idx       = LEN_W'(cnt_q - CNT_W'(1));

        if (bus.rdy) begin
            wr_done_d = 1'b0;
            rd_done_d = '0;
            case (state_q)
                IDLE: begin
                    if (bus.wr_valid && !wr_done_q && !wr_block) begin
                        state_d       = WRITE;
                        wr_data_d     = bus.wr_data;
                        len_d         = LEN_W'(bus.wr_len);
                        cnt_d         = '0;
                        ram_rw_sel_d  = 1'b1;
                        ram_addr_d    = bus.wr_addr;
                        ram_wr_byte_d = bus.wr_data[7:0];
                    end else if (gnt_found) begin
                        state_d      = READ;
                        ch_d         = gnt_ch;
                        ptr_d        = CH_W'((int'(gnt_ch) + 1) % RD_CH);
                        ram_addr_d   = bus.rd_addr[int'(gnt_ch)*32 +: 32];
                        len_d        = bus.rd_len[int'(gnt_ch)*LEN_W +: LEN_W];
                        cnt_d        = '0;
                        buf_d        = '0;
                        ram_rw_sel_d = 1'b0;
                    end
                end
                WRITE: begin
                    if (cnt_q == CNT_W'(len_q)) begin
                        wr_done_d     = 1'b1;
                        state_d       = IDLE;
                        ram_rw_sel_d  = 1'b0;
                        ram_addr_d    = '0;
                        ram_wr_byte_d = '0;
                    end else begin
                        cnt_d         = cnt_nxt;
                        ram_addr_d    = ram_addr_q + 32'd1;
                        ram_wr_byte_d = wr_data_q[{cnt_nxt[1:0], 3'b000} +: 8];
                    end
                end
                READ: begin
                    if (bus.flush && KILL_MASK[ch_q]) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_nxt;
                        if (cnt_q < CNT_W'(len_q)) begin
                            ram_addr_d = ram_addr_q + 32'd1;
                        end
                        // RAM data lags the address by one cycle, so capture trails cnt by one.
                        if (cnt_q != '0) begin
                            buf_d[{cap_idx, 3'b000} +: 8] = bus.ram_rd_byte;
                            if (cnt_q == len_p1) begin
                                rd_data_d = buf_d;
                                rd_done_d = RD_CH'(1) << ch_q;
                                state_d   = IDLE;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            len_q         <= '0;
            ch_q          <= '0;
            ptr_q         <= '0;
            wr_data_q     <= '0;
            ram_addr_q    <= '0;
            ram_rw_sel_q  <= 1'b0;
            ram_wr_byte_q <= '0;
            wr_done_q     <= 1'b0;
            rd_done_q     <= '0;
            rd_data_q     <= '0;
            buf_q         <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            len_q         <= len_d;
            ch_q          <= ch_d;
            ptr_q         <= ptr_d;
            wr_data_q     <= wr_data_d;
            ram_addr_q    <= ram_addr_d;
            ram_rw_sel_q  <= ram_rw_sel_d;
            ram_wr_byte_q <= ram_wr_byte_d;
            wr_done_q     <= wr_done_d;
            rd_done_q     <= rd_done_d;
            rd_data_q     <= rd_data_d;
            buf_q         <= buf_d;
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.wr_done     = wr_done_q;
    assign bus.rd_done     = rd_done_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.ram_rw_sel  = ram_rw_sel_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_wr_byte = ram_wr_byte_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transactions push expected completions,
// a negedge monitor pops and compares kind, channel, cycle and read data.
module tb_mem_arbiter;
    localparam int LINE_BYTES = 16;
    localparam int RD_CH      = 2;
    localparam int LEN_W      = 4;

    typedef struct {
        bit           is_wr;
        int           ch;
        logic [127:0] data;
        int           cyc;
    } sb_item_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    sb_item_t sbq[$];
    logic [7:0] mem [0:4095];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter_if #(.LINE_BYTES(LINE_BYTES), .RD_CH(RD_CH)) bus ();

    mem_arbiter #(.LINE_BYTES(LINE_BYTES), .RD_CH(RD_CH), .KILL_MASK(2'b01)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    function automatic logic [7:0] init_byte(int a);
        if (a >= 'h200 && a < 'h210) return 8'(a - 'h200);
        case (a)
            'h300: return 8'h11;
            'h301: return 8'h22;
            'h500: return 8'h80;
            'h501: return 8'h7F;
            default: return 8'h00;
        endcase
    endfunction

    // RAM model with one-cycle read latency; it shares the global enable with the controller.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4096; i++) mem[i] <= init_byte(i);
            bus.ram_rd_byte <= 8'h00;
        end else if (bus.rdy) begin
            if (bus.ram_rw_sel) mem[bus.ram_addr[11:0]] <= bus.ram_wr_byte;
            bus.ram_rd_byte <= mem[bus.ram_addr[11:0]];
        end
    end

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        sb_item_t e;
        if (rst && (bus.wr_done || bus.rd_done != '0)) begin
            if (sbq.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: got wr_done=%b rd_done=%b at cycle %0d, expected no completion",
                         bus.wr_done, bus.rd_done, cyc);
            end else begin
                e = sbq.pop_front();
                check("done_is_write", 128'(bus.wr_done), 128'(e.is_wr));
                check("done_rd_onehot", 128'(bus.rd_done), e.is_wr ? 128'(0) : 128'(1) << e.ch);
                check("done_cycle", 128'(cyc), 128'(e.cyc));
                if (!e.is_wr) check("rd_data", bus.rd_data, e.data);
            end
        end
    end

    task automatic push(bit is_wr, int ch, logic [127:0] data, int at);
        sb_item_t e;
        e.is_wr = is_wr; e.ch = ch; e.data = data; e.cyc = at;
        sbq.push_back(e);
    endtask

    task automatic wait_until(int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_done(string name, int budget);
        int k = 0;
        while (!(bus.wr_done || bus.rd_done != '0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (k >= budget) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: got no done within %0d cycles, expected a done pulse", name, budget);
        end
    endtask

    task automatic wait_drain(string name, int budget);
        int k = 0;
        while (sbq.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (sbq.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_drain: got %0d outstanding completions, expected 0", name, sbq.size());
            sbq.delete();
        end
    endtask

    task automatic do_write(logic [31:0] addr, logic [31:0] data, logic [1:0] len, logic with_flush);
        bus.wr_addr  = addr;
        bus.wr_data  = data;
        bus.wr_len   = len;
        bus.wr_valid = 1'b1;
        bus.flush    = with_flush;
        push(1'b1, 0, '0, cyc + 2 + int'(len));
        @(negedge clk);
        bus.flush = 1'b0;
        wait_done("write", 60);
        bus.wr_valid = 1'b0;
        wait_drain("write", 5);
    endtask

    task automatic do_read(int ch, logic [31:0] addr, logic [3:0] len, logic [127:0] data);
        bus.rd_addr[ch*32 +: 32]    = addr;
        bus.rd_len[ch*LEN_W +: LEN_W] = len;
        bus.rd_valid[ch]            = 1'b1;
        push(1'b0, ch, data, cyc + 3 + int'(len));
        wait_done("read", 60);
        bus.rd_valid[ch] = 1'b0;
        wait_drain("read", 5);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        bus.rdy = 1'b1; bus.flush = 1'b0;
        bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_len = '0;
        bus.rd_valid = '0; bus.rd_addr = '0; bus.rd_len = '0;
`ifdef MEMCTRL_IO_STALL_EN
        bus.io_buffer_full = 1'b0;
`endif
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 128'(bus.busy), 0);
        check("rst_wr_done", 128'(bus.wr_done), 0);
        check("rst_rd_done", 128'(bus.rd_done), 0);
        check("rst_rd_data", bus.rd_data, 0);
        check("rst_ram_addr", 128'(bus.ram_addr), 0);
        check("rst_ram_rw_sel", 128'(bus.ram_rw_sel), 0);
        check("rst_ram_wr_byte", 128'(bus.ram_wr_byte), 0);
        rst = 1'b1;
        @(negedge clk);

        do_write(32'h100, 32'hDEADBEEF, 2'd3, 1'b0);
        check("wr_mem_100", 128'(mem['h100]), 128'hEF);
        check("wr_mem_101", 128'(mem['h101]), 128'hBE);
        check("wr_mem_102", 128'(mem['h102]), 128'hAD);
        check("wr_mem_103", 128'(mem['h103]), 128'hDE);
        check("wr_end_rw_sel", 128'(bus.ram_rw_sel), 0);
        check("wr_end_addr", 128'(bus.ram_addr), 0);

        do_read(1, 32'h200, 4'd15, 128'h0F0E0D0C0B0A09080706050403020100);
        do_read(0, 32'h500, 4'd1, 128'h7F80);
        do_read(1, 32'h100, 4'd3, 128'hDEADBEEF);

        // Address wrap plus flush in the same IDLE cycle as the write request.
        do_write(32'hFFFF_FFFF, 32'h0000_A55A, 2'd1, 1'b1);
        check("wrap_mem_fff", 128'(mem['hFFF]), 128'h5A);
        check("wrap_mem_000", 128'(mem['h000]), 128'hA5);

        // Round-robin with both channels always requesting; a write cuts in mid-stream.
        c = cyc;
        bus.rd_addr = {32'h301, 32'h300};
        bus.rd_len  = '0;
        bus.rd_valid = 2'b11;
        push(1'b0, 0, 128'h11, c + 3);
        push(1'b0, 1, 128'h22, c + 6);
        push(1'b0, 0, 128'h11, c + 9);
        push(1'b0, 1, 128'h22, c + 12);
        push(1'b1, 0, '0,      c + 14);
        push(1'b0, 0, 128'h11, c + 17);
        wait_until(c + 10);
        bus.wr_addr = 32'h400; bus.wr_data = 32'h5A; bus.wr_len = 2'd0; bus.wr_valid = 1'b1;
        wait_until(c + 14);
        bus.wr_valid = 1'b0;
        wait_until(c + 17);
        bus.rd_valid = 2'b00;
        wait_drain("round_robin", 10);
        check("rr_write_mem", 128'(mem['h400]), 128'h5A);

        // Flush kills a channel-0 read.
        c = cyc;
        bus.rd_addr[31:0] = 32'h200; bus.rd_len[3:0] = 4'd15; bus.rd_valid[0] = 1'b1;
        wait_until(c + 2);
        bus.flush = 1'b1; bus.rd_valid[0] = 1'b0;
        wait_until(c + 3);
        bus.flush = 1'b0;
        check("kill_idle", 128'(bus.busy), 0);
        repeat (20) @(negedge clk);
        check("kill_rd_data_kept", bus.rd_data, 128'h11);
        check("kill_no_done", 128'(bus.rd_done), 0);

        // Same flush on channel 1 does not abort it.
        c = cyc;
        bus.rd_addr[63:32] = 32'h200; bus.rd_len[7:4] = 4'd15; bus.rd_valid[1] = 1'b1;
        push(1'b0, 1, 128'h0F0E0D0C0B0A09080706050403020100, c + 18);
        wait_until(c + 2);
        bus.flush = 1'b1;
        wait_until(c + 3);
        bus.flush = 1'b0;
        check("flush_ch1_busy", 128'(bus.busy), 1);
        wait_done("flush_ch1", 40);
        bus.rd_valid[1] = 1'b0;
        wait_drain("flush_ch1", 5);

        // rdy low freezes a channel-0 read for three edges; a flush meanwhile is ignored.
        c = cyc;
        bus.rd_addr[31:0] = 32'h200; bus.rd_len[3:0] = 4'd3; bus.rd_valid[0] = 1'b1;
        push(1'b0, 0, 128'h03020100, c + 9);
        wait_until(c + 2);
        bus.rdy = 1'b0; bus.flush = 1'b1;
        wait_until(c + 5);
        check("rdy_low_busy", 128'(bus.busy), 1);
        bus.rdy = 1'b1; bus.flush = 1'b0;
        wait_done("rdy_stall", 40);
        bus.rd_valid[0] = 1'b0;
        wait_drain("rdy_stall", 5);

`ifdef MEMCTRL_IO_STALL_EN
        c = cyc;
        bus.io_buffer_full = 1'b1;
        bus.wr_addr = 32'h30000; bus.wr_data = 32'h77; bus.wr_len = 2'd0; bus.wr_valid = 1'b1;
        wait_until(c + 4);
        check("io_stall_no_grant", 128'(bus.busy), 0);
        bus.io_buffer_full = 1'b0;
        push(1'b1, 0, '0, c + 6);
        wait_done("io_stall", 20);
        bus.wr_valid = 1'b0;
        wait_drain("io_stall", 5);
        check("io_stall_mem", 128'(mem['h000]), 128'h77);
`endif

        // Reset in the middle of a read: everything returns to reset values, no done.
        c = cyc;
        bus.rd_addr[63:32] = 32'h200; bus.rd_len[7:4] = 4'd15; bus.rd_valid[1] = 1'b1;
        wait_until(c + 5);
        check("mid_busy_before", 128'(bus.busy), 1);
        rst = 1'b0;
        #1;
        check("mid_rst_busy", 128'(bus.busy), 0);
        check("mid_rst_rd_data", bus.rd_data, 0);
        check("mid_rst_ram_addr", 128'(bus.ram_addr), 0);
        check("mid_rst_rd_done", 128'(bus.rd_done), 0);
        bus.rd_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        repeat (25) @(negedge clk);
        check("mid_rst_idle_after", 128'(bus.busy), 0);
        check("sb_empty", 128'(sbq.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
